// File: rtl/fp32_mult.sv
// fp32_mult: two-stage IEEE-754 binary32 multiplier.
// Denormal inputs are treated as zero, and denormal results are flushed to signed zero.
// Build option FP32_MULT_ROUND_EN selects round-to-nearest-even.
// When it is undefined, the mantissa is truncated (round toward zero).
module fp32_mult (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

`ifdef FP32_MULT_ROUND_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  // CLS_ZERO is encoded as 0 so that a reset stage-1 register drains as a clean zero.
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_t;

  // Return {carry, mantissa} after the optional round-to-nearest-even increment.
  function automatic logic [23:0] round_mant(input logic [22:0] mant,
                                             input logic        guard,
                                             input logic        sticky);
    logic up;
    up = RNE & guard & (sticky | mant[0]);
    return {1'b0, mant} + {23'd0, up};
  endfunction

  // Pack a finite result with exponent saturation: returns {overflow, underflow, word}.
  function automatic logic [33:0] pack_finite(input logic               sign,
                                              input logic signed [9:0]  exp,
                                              input logic [22:0]        mant);
    if (exp >= 10'sd255)
      return {2'b10, sign, 8'hFF, 23'd0};
    else if (exp <= 10'sd0)
      return {2'b01, sign, 31'd0};
    else
      return {2'b00, sign, exp[7:0], mant};
  endfunction

  // ---- stage 0: operand decode, classification, exponent sum, mantissa product ----
  logic [7:0]         ea_p0, eb_p0;
  logic [22:0]        ma_p0, mb_p0;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               sign_p0;
  logic signed [9:0]  exp_p0;
  logic [47:0]        prod_p0;
  cls_t               cls_p0;

  // Decode both operands and classify the pair.
  always_comb begin
    ea_p0   = A[30:23];
    eb_p0   = B[30:23];
    ma_p0   = A[22:0];
    mb_p0   = B[22:0];
    a_zero  = (ea_p0 == 8'd0);
    b_zero  = (eb_p0 == 8'd0);
    a_inf   = (ea_p0 == 8'hFF) && (ma_p0 == 23'd0);
    b_inf   = (eb_p0 == 8'hFF) && (mb_p0 == 23'd0);
    a_nan   = (ea_p0 == 8'hFF) && (ma_p0 != 23'd0);
    b_nan   = (eb_p0 == 8'hFF) && (mb_p0 != 23'd0);
    sign_p0 = A[31] ^ B[31];
    exp_p0  = $signed({2'b00, ea_p0}) + $signed({2'b00, eb_p0}) - 10'sd127;
    prod_p0 = {24'd0, 1'b1, ma_p0} * {24'd0, 1'b1, mb_p0};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      cls_p0 = CLS_NAN;
    else if (a_inf || b_inf)
      cls_p0 = CLS_INF;
    else if (a_zero || b_zero)
      cls_p0 = CLS_ZERO;
    else
      cls_p0 = CLS_NORM;
  end

  // ---- stage 1 registers ----
  logic               sign_p1;
  logic signed [9:0]  exp_p1;
  logic [47:0]        prod_p1;
  cls_t               cls_p1;

  // Capture the decoded pair; reset empties the pipeline.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sign_p1 <= 1'b0;
      exp_p1  <= '0;
      prod_p1 <= '0;
      cls_p1  <= CLS_ZERO;
    end else begin
      sign_p1 <= sign_p0;
      exp_p1  <= exp_p0;
      prod_p1 <= prod_p0;
      cls_p1  <= cls_p0;
    end
  end

  // ---- stage 1 -> 2: normalize, round, apply exceptions ----
  logic [22:0]        mant_n;
  logic               guard, sticky;
  logic signed [9:0]  exp_n, exp_r;
  logic [23:0]        rnd;
  logic [33:0]        fin;
  logic [31:0]        res_n;
  logic               ovf_n, unf_n;

  // Normalize a [1,4) product to [1,2).
  // A rounding carry-out leaves the mantissa at zero and bumps the exponent.
  always_comb begin
    if (prod_p1[47]) begin
      mant_n = prod_p1[46:24];
      guard  = prod_p1[23];
      sticky = |prod_p1[22:0];
      exp_n  = exp_p1 + 10'sd1;
    end else begin
      mant_n = prod_p1[45:23];
      guard  = prod_p1[22];
      sticky = |prod_p1[21:0];
      exp_n  = exp_p1;
    end
    rnd   = round_mant(mant_n, guard, sticky);
    exp_r = exp_n + $signed({9'd0, rnd[23]});
    fin   = pack_finite(sign_p1, exp_r, rnd[22:0]);
    res_n = 32'd0;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    case (cls_p1)
      CLS_NAN:  res_n = 32'h7FC0_0000;
      CLS_INF:  res_n = {sign_p1, 8'hFF, 23'd0};
      CLS_ZERO: res_n = {sign_p1, 31'd0};
      default: begin
        res_n = fin[31:0];
        ovf_n = fin[33];
        unf_n = fin[32];
      end
    endcase
  end

  // ---- stage 2 registers ----
  logic [31:0] result_p2;
  logic        ovf_p2, unf_p2;

  // Register the final word and flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      result_p2 <= '0;
      ovf_p2    <= 1'b0;
      unf_p2    <= 1'b0;
    end else begin
      result_p2 <= res_n;
      ovf_p2    <= ovf_n;
      unf_p2    <= unf_n;
    end
  end

  assign result    = result_p2;
  assign overflow  = ovf_p2;
  assign underflow = unf_p2;

endmodule

// File: tb/tb_fp32_mult.sv
// tb_fp32_mult: directed vectors for fp32_mult.
// The vectors cover reset behaviour, latency, streaming, rounding and exceptions.
module tb_fp32_mult;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  fp32_mult dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic ovf, input logic unf);
    vec_t v;
    v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] res,
                            input logic ovf, input logic unf);
    check({tag, "_res"}, result, res);
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ovf});
    check({tag, "_unf"}, {31'd0, underflow}, {31'd0, unf});
  endtask

  initial begin
    // Directed table: operands and hand-computed product/flags.
    add(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0, 1'b0); // 2*3
    add(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0); // 1.5*1.5
`ifdef FP32_MULT_ROUND_EN
    add(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 1'b0, 1'b0);
    add(32'h3FA1_E58F, 32'h3FCA_6691, 32'h4000_0000, 1'b0, 1'b0); // rounding carry-out
    add(32'h7F21_E58F, 32'h3FCA_6691, 32'h7F80_0000, 1'b1, 1'b0); // carry-out overflows
`else
    add(32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0001, 1'b0, 1'b0);
    add(32'h3FA1_E58F, 32'h3FCA_6691, 32'h3FFF_FFFF, 1'b0, 1'b0);
    add(32'h7F21_E58F, 32'h3FCA_6691, 32'h7F7F_FFFF, 1'b0, 1'b0);
`endif
    add(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1, 1'b0);
    add(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b0, 1'b1);
    add(32'hBF80_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
    add(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    add(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
    add(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0);
    add(32'h0080_0000, 32'h3F80_0000, 32'h0080_0000, 1'b0, 1'b0); // exactly min normal
    add(32'h8080_0000, 32'h3F00_0000, 32'h8000_0000, 1'b0, 1'b1); // exp lands on 0
    add(32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0); // denormal input
    add(32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0); // inf*inf
    add(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 1'b0, 1'b0); // -2*3
    add(32'h3F80_0000, 32'h7FFF_FFFF, 32'h7FC0_0000, 1'b0, 1'b0); // NaN on B

    // Reset is asynchronous: outputs are 0 before any clock edge.
    A = 32'h4040_0000; B = 32'h4000_0000;
    #1 RST = 1'b1;
    #1 check_outs("rst_async", 32'd0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    check_outs("rst_held", 32'd0, 1'b0, 1'b0);

    // Release, then observe the two-edge latency.
    RST = 1'b0;
    A = 32'h3F80_0000; B = 32'h5540_E2B9;
    @(negedge CLK);
    check_outs("rel_lat1", 32'd0, 1'b0, 1'b0);
    @(negedge CLK);
    check_outs("rel_res", 32'h5540_E2B9, 1'b0, 1'b0);

    // Back-to-back stream, one pair per cycle.
    for (int i = 0; i < vecs.size() + 2; i++) begin
      if (i >= 2)
        check_outs($sformatf("v%0d", i - 2), vecs[i-2].res, vecs[i-2].ovf, vecs[i-2].unf);
      if (i < vecs.size()) begin
        A = vecs[i].a;
        B = vecs[i].b;
      end
      @(negedge CLK);
    end

    // Mid-cycle reset while nonzero results flow.
    A = 32'h4000_0000; B = 32'h4040_0000;
    repeat (3) @(negedge CLK);
    check_outs("flow", 32'h40C0_0000, 1'b0, 1'b0);
    @(posedge CLK);
    #2 RST = 1'b1;
    A = 32'h3FC0_0000; B = 32'h3FC0_0000;
    #1 check_outs("rst_mid", 32'd0, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_outs("rst_mid_lat1", 32'd0, 1'b0, 1'b0);
    @(negedge CLK);
    check_outs("rst_mid_res", 32'h4010_0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
